// File: rtl/pmod_enc_pkg.sv
// Shared constants, decoder state type and Gray helpers for the PMOD ENC slot core.
package pmod_enc_pkg;

    localparam int DB_W = 20;

    localparam logic [1:0] REG_POS  = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_DB   = 2'd3;

    localparam int STAT_BTN     = 0;
    localparam int STAT_SW      = 1;
    localparam int STAT_DIR     = 2;
    localparam int STAT_MOVED   = 3;
    localparam int STAT_PRESS   = 4;
    localparam int STAT_ERR     = 5;
    localparam int STAT_CNT_LSB = 8;

    localparam int CTRL_CLR_POS   = 0;
    localparam int CTRL_CLR_FLAGS = 1;
    localparam int CTRL_CLR_CNT   = 2;
    localparam int CTRL_EN        = 8;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        S00  = 3'd1,
        S01  = 3'd2,
        S11  = 3'd3,
        S10  = 3'd4
    } enc_state_t;

    function automatic enc_state_t ab_to_state(input logic [1:0] ab);
        case (ab)
            2'b00:   return S00;
            2'b01:   return S01;
            2'b11:   return S11;
            2'b10:   return S10;
            default: return INIT;
        endcase
    endfunction

    function automatic logic [1:0] state_to_ab(input enc_state_t s);
        case (s)
            S00:     return 2'b00;
            S01:     return 2'b01;
            S11:     return 2'b11;
            S10:     return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Position of an AB code along the clockwise cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            2'b01:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pmod_enc_if.sv
// FPro MMIO slot bus between the sampler subsystem and the encoder core.
interface pmod_enc_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/enc_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw pin.
module enc_debounce #(
    parameter logic RST_VAL = 1'b0,
    parameter int   CNT_W   = 20
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pin,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_level
);
    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Metastability synchronizer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    // Counter runs only while the input disagrees; >= keeps a lowered limit from wrapping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_level <= RST_VAL;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt >= i_limit) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_level = r_level;
endmodule

// File: rtl/pmod_enc_core.sv
// PMOD ENC slot core: conditioned pins, quadrature decoder FSM, counters, flags and MMIO registers.
module pmod_enc_core
    import pmod_enc_pkg::*;
#(
    parameter int              W          = 16,
    parameter logic [DB_W-1:0] DB_DEFAULT = 20'd10_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    pmod_enc_if.slave  io_bus,
    input  logic       i_enc_a,
    input  logic       i_enc_b,
    input  logic       i_enc_btn,
    input  logic       i_enc_sw
);
    logic w_db_a, w_db_b, w_db_btn, w_db_sw;
    logic [DB_W-1:0] r_db_lim;

    enc_debounce #(.RST_VAL(1'b1), .CNT_W(DB_W)) u_db_a (
        .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_enc_a), .i_limit(r_db_lim), .o_level(w_db_a));
    enc_debounce #(.RST_VAL(1'b1), .CNT_W(DB_W)) u_db_b (
        .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_enc_b), .i_limit(r_db_lim), .o_level(w_db_b));
    enc_debounce #(.RST_VAL(1'b0), .CNT_W(DB_W)) u_db_btn (
        .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_enc_btn), .i_limit(r_db_lim), .o_level(w_db_btn));
    enc_debounce #(.RST_VAL(1'b0), .CNT_W(DB_W)) u_db_sw (
        .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_enc_sw), .i_limit(r_db_lim), .o_level(w_db_sw));

    enc_state_t  r_state, w_state_nxt;
    logic [1:0]  w_ab, w_delta;
    logic        w_step_cw, w_step_ccw, w_gray_err;

    assign w_ab = {w_db_a, w_db_b};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The state always follows AB; the distance travelled along the Gray cycle classifies the move.
    always_comb begin
        w_state_nxt = ab_to_state(w_ab);
        w_delta     = gray_idx(w_ab) - gray_idx(state_to_ab(r_state));
        w_step_cw   = 1'b0;
        w_step_ccw  = 1'b0;
        w_gray_err  = 1'b0;
        case (r_state)
            S00, S01, S11, S10: begin
                case (w_delta)
                    2'd1:    w_step_cw  = 1'b1;
                    2'd3:    w_step_ccw = 1'b1;
                    2'd2:    w_gray_err = 1'b1;
                    default: w_step_cw  = 1'b0;
                endcase
            end
            default: w_step_cw = 1'b0;
        endcase
    end

    logic         r_en, r_dir, r_moved, r_press, r_err, r_btn_prev;
    logic [W-1:0] r_pos;
    logic [7:0]   r_press_cnt;
    logic         w_wr, w_wr_pos, w_wr_ctrl, w_wr_db;
    logic         w_clr_pos, w_clr_flags, w_clr_cnt;
    logic         w_step, w_err_ev, w_press_ev;

    assign w_wr        = io_bus.cs & io_bus.write;
    assign w_wr_pos    = w_wr & (io_bus.addr[1:0] == REG_POS);
    assign w_wr_ctrl   = w_wr & (io_bus.addr[1:0] == REG_CTRL);
    assign w_wr_db     = w_wr & (io_bus.addr[1:0] == REG_DB);
    assign w_clr_pos   = w_wr_ctrl & io_bus.wr_data[CTRL_CLR_POS];
    assign w_clr_flags = w_wr_ctrl & io_bus.wr_data[CTRL_CLR_FLAGS];
    assign w_clr_cnt   = w_wr_ctrl & io_bus.wr_data[CTRL_CLR_CNT];
    assign w_step      = r_en & (w_step_cw | w_step_ccw);
    assign w_err_ev    = r_en & w_gray_err;
    assign w_press_ev  = w_db_btn & ~r_btn_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pos <= '0;
        end else if (w_wr_pos) begin
            r_pos <= io_bus.wr_data[W-1:0];
        end else if (w_clr_pos) begin
            r_pos <= '0;
        end else if (r_en & w_step_cw) begin
            r_pos <= r_pos + W'(1);
        end else if (r_en & w_step_ccw) begin
            r_pos <= r_pos - W'(1);
        end
    end

    // Sticky flags: a fresh event outranks a clear in the same cycle; the count clear outranks increment.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dir       <= 1'b0;
            r_moved     <= 1'b0;
            r_press     <= 1'b0;
            r_err       <= 1'b0;
            r_btn_prev  <= 1'b0;
            r_press_cnt <= 8'd0;
        end else begin
            r_moved    <= w_step     | (r_moved & ~w_clr_flags);
            r_err      <= w_err_ev   | (r_err   & ~w_clr_flags);
            r_press    <= w_press_ev | (r_press & ~w_clr_flags);
            r_btn_prev <= w_db_btn;
            if (w_step) begin
                r_dir <= w_step_cw;
            end
            if (w_clr_cnt) begin
                r_press_cnt <= 8'd0;
            end else if (w_press_ev && (r_press_cnt != 8'hFF)) begin
                r_press_cnt <= r_press_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_en     <= 1'b1;
            r_db_lim <= DB_DEFAULT;
        end else begin
            if (w_wr_ctrl) begin
                r_en <= io_bus.wr_data[CTRL_EN];
            end
            if (w_wr_db) begin
                r_db_lim <= io_bus.wr_data[DB_W-1:0];
            end
        end
    end

    logic [31:0] w_stat, w_ctrl, w_rd;
    logic        w_unused_bits;

    always_comb begin
        w_stat                         = 32'd0;
        w_stat[STAT_BTN]               = w_db_btn;
        w_stat[STAT_SW]                = w_db_sw;
        w_stat[STAT_DIR]               = r_dir;
        w_stat[STAT_MOVED]             = r_moved;
        w_stat[STAT_PRESS]             = r_press;
        w_stat[STAT_ERR]               = r_err;
        w_stat[STAT_CNT_LSB +: 8]      = r_press_cnt;
        w_ctrl                         = 32'd0;
        w_ctrl[CTRL_EN]                = r_en;
    end

    always_comb begin
        w_rd = 32'd0;
        case (io_bus.addr[1:0])
            REG_POS:  w_rd = 32'(signed'(r_pos));
            REG_STAT: w_rd = w_stat;
            REG_CTRL: w_rd = w_ctrl;
            REG_DB:   w_rd = {{(32-DB_W){1'b0}}, r_db_lim};
            default:  w_rd = 32'd0;
        endcase
    end

    assign io_bus.rd_data = w_rd;
    assign w_unused_bits  = ^{io_bus.read, io_bus.addr[4:2], io_bus.wr_data};
endmodule

// File: tb/tb_pmod_enc_core.sv
// Directed bench for pmod_enc_core with a cycle-level reference model checked every cycle.
module tb_pmod_enc_core;
    logic clk = 1'b0;
    logic rst;
    logic pin_a, pin_b, pin_btn, pin_sw;
    always #5 clk = ~clk;

    pmod_enc_if bus();

    pmod_enc_core #(.W(16), .DB_DEFAULT(20'd3)) dut (
        .i_clk(clk), .i_reset(rst), .io_bus(bus),
        .i_enc_a(pin_a), .i_enc_b(pin_b), .i_enc_btn(pin_btn), .i_enc_sw(pin_sw));

    int n_checks = 0;
    int n_err    = 0;
    int rr       = 0;
    logic        lit_req = 1'b0;
    logic [31:0] lit_exp;
    string       lit_name;

    // Reference model state: register contents and debounced pin levels as software would see them.
    logic        m_valid = 1'b0;
    logic [15:0] m_pos;
    logic        m_dir, m_moved, m_press, m_err, m_en;
    logic [7:0]  m_cnt;
    logic [19:0] m_lim;
    logic        m_db [4];
    logic        m_dbp [4];
    logic        hist [4][64];
    logic        rstv [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0]  ring [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    function automatic int gidx(input logic a, input logic b);
        for (int i = 0; i < 4; i++) if (ring[i] == {a, b}) return i;
        return 0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {{16{m_pos[15]}}, m_pos};
            2'd1:    return {16'd0, m_cnt, 2'b00, m_err, m_press, m_moved, m_dir, m_db[3], m_db[2]};
            2'd2:    return m_en ? 32'h0000_0100 : 32'h0;
            default: return {12'd0, m_lim};
        endcase
    endfunction

    task automatic model_edge();
        int d;
        logic wr, ev_step, ev_err, ev_press, tog;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [19:0] old_lim;
        logic pins [4];
        if (rst) begin
            m_pos = 16'd0; m_dir = 1'b0; m_moved = 1'b0; m_press = 1'b0; m_err = 1'b0;
            m_cnt = 8'd0; m_en = 1'b1; m_lim = 20'd3; m_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                m_db[i] = rstv[i]; m_dbp[i] = rstv[i];
                for (int j = 0; j < 64; j++) hist[i][j] = rstv[i];
            end
        end else begin
            // A move is judged from the last two debounced AB values; quarter-cycle distance 2 is illegal.
            d = (gidx(m_db[0], m_db[1]) - gidx(m_dbp[0], m_dbp[1]) + 4) % 4;
            ev_step  = m_en && (d == 1 || d == 3);
            ev_err   = m_en && (d == 2);
            ev_press = m_db[2] && !m_dbp[2];
            wr = bus.cs && bus.write; a = bus.addr[1:0]; wd = bus.wr_data;
            if (ev_step) begin
                m_pos = (d == 1) ? m_pos + 16'd1 : m_pos - 16'd1;
                m_dir = (d == 1);
            end
            if (wr && a == 2'd0) m_pos = wd[15:0];
            if (wr && a == 2'd2 && wd[0]) m_pos = 16'd0;
            if (wr && a == 2'd2 && wd[1]) begin m_moved = 1'b0; m_press = 1'b0; m_err = 1'b0; end
            if (ev_step)  m_moved = 1'b1;
            if (ev_err)   m_err   = 1'b1;
            if (ev_press) m_press = 1'b1;
            if (wr && a == 2'd2 && wd[2]) m_cnt = 8'd0;
            else if (ev_press && m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
            old_lim = m_lim;
            if (wr && a == 2'd2) m_en = wd[8];
            if (wr && a == 2'd3) m_lim = wd[19:0];
            // A level flips once the synchronized pin has disagreed for limit+1 consecutive samples.
            pins[0] = pin_a; pins[1] = pin_b; pins[2] = pin_btn; pins[3] = pin_sw;
            for (int i = 0; i < 4; i++) begin
                for (int j = 63; j > 0; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = pins[i];
                tog = 1'b1;
                for (int j = 2; j <= int'(old_lim) + 2 && j < 64; j++)
                    if (hist[i][j] == m_db[i]) tog = 1'b0;
                m_dbp[i] = m_db[i];
                if (tog) m_db[i] = !m_db[i];
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        logic [31:0] exp;
        @(negedge clk);
        if (m_valid) begin
            exp = model_rd(bus.addr[1:0]);
            n_checks++;
            if (bus.rd_data !== exp) begin
                n_err++;
                $display("FAIL model_rd addr=%0d got=%h exp=%h t=%0t", bus.addr, bus.rd_data, exp, $time);
            end
            if (lit_req) begin
                n_checks++;
                if (bus.rd_data !== lit_exp) begin
                    n_err++;
                    $display("FAIL %s got=%h exp=%h", lit_name, bus.rd_data, lit_exp);
                end
            end
        end
    end

    task automatic tick(); @(negedge clk); #1; endtask

    task automatic bus_idle();
        bus.cs = 1'b1; bus.read = 1'b1; bus.write = 1'b0;
        bus.addr = 5'(rr % 4); bus.wr_data = 32'h0; rr++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin tick(); bus_idle(); end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        tick(); bus.cs = 1'b1; bus.read = 1'b0; bus.write = 1'b1; bus.addr = {3'b000, a}; bus.wr_data = d;
        tick(); bus_idle();
    endtask

    task automatic read_chk(input logic [1:0] a, input logic [31:0] e, input string nm);
        tick(); bus.cs = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.addr = {3'b000, a};
        lit_exp = e; lit_name = nm; lit_req = 1'b1;
        tick(); lit_req = 1'b0; bus_idle();
    endtask

    task automatic step(input bit cw, input int hold);
        int idx;
        logic [1:0] nxt;
        tick();
        idx = gidx(pin_a, pin_b);
        nxt = ring[cw ? (idx + 1) % 4 : (idx + 3) % 4];
        pin_a = nxt[1]; pin_b = nxt[0];
        bus_idle();
        idle(hold - 1);
    endtask

    task automatic press();
        tick(); pin_btn = 1'b1; bus_idle(); idle(6);
        tick(); pin_btn = 1'b0; bus_idle(); idle(6);
    endtask

    initial begin
        rst = 1'b1; pin_a = 1'b1; pin_b = 1'b1; pin_btn = 1'b0; pin_sw = 1'b0;
        bus_idle();
        idle(4);
        tick(); rst = 1'b0; bus_idle();
        idle(10);
        read_chk(2'd0, 32'h0, "reset_pos");
        read_chk(2'd1, 32'h0, "reset_stat");
        read_chk(2'd2, 32'h100, "reset_ctrl");
        read_chk(2'd3, 32'h3, "reset_db");

        repeat (8) step(1'b1, 10);
        read_chk(2'd0, 32'h8, "cw8_pos");
        read_chk(2'd1, 32'h0C, "cw8_stat");

        wr(2'd2, 32'h103);
        read_chk(2'd0, 32'h0, "clr_pos");
        read_chk(2'd1, 32'h04, "clr_flags");
        repeat (8) step(1'b0, 10);
        read_chk(2'd0, 32'hFFFF_FFF8, "ccw8_pos");
        read_chk(2'd1, 32'h08, "ccw8_stat");

        tick(); pin_a = 1'b0; bus_idle(); idle(1);
        tick(); pin_a = 1'b1; bus_idle(); idle(10);
        read_chk(2'd0, 32'hFFFF_FFF8, "glitch_pos");

        step(1'b1, 10); step(1'b1, 10);
        tick(); pin_a = 1'b1; pin_b = 1'b1; bus_idle(); idle(10);
        read_chk(2'd0, 32'hFFFF_FFFA, "gray_err_pos");
        read_chk(2'd1, 32'h2C, "gray_err_stat");

        wr(2'd0, 32'h7FFF);
        read_chk(2'd0, 32'h0000_7FFF, "load_pos");
        step(1'b1, 10);
        read_chk(2'd0, 32'hFFFF_8000, "wrap_pos");

        tick(); pin_a = 1'b0; pin_b = 1'b0; bus_idle(); idle(5);
        wr(2'd0, 32'h5);
        idle(10);
        read_chk(2'd0, 32'h5, "load_beats_step");

        wr(2'd2, 32'h102);
        read_chk(2'd1, 32'h04, "flags_cleared");
        repeat (300) press();
        read_chk(2'd1, 32'hFF14, "press_sat");
        wr(2'd2, 32'h102);
        read_chk(2'd1, 32'hFF04, "press_clr");
        tick(); pin_btn = 1'b1; bus_idle(); idle(5);
        wr(2'd2, 32'h102);
        idle(10);
        read_chk(2'd1, 32'hFF15, "press_beats_clr");
        tick(); pin_btn = 1'b0; bus_idle(); idle(10);
        wr(2'd2, 32'h104);
        read_chk(2'd1, 32'h0014, "cnt_clr");
        tick(); pin_sw = 1'b1; bus_idle(); idle(10);
        read_chk(2'd1, 32'h0016, "sw_level");
        tick(); pin_sw = 1'b0; bus_idle(); idle(10);

        wr(2'd2, 32'h0);
        read_chk(2'd2, 32'h0, "ctrl_dis");
        repeat (4) step(1'b1, 10);
        tick(); pin_a = 1'b1; pin_b = 1'b1; bus_idle(); idle(10);
        tick(); pin_a = 1'b0; pin_b = 1'b0; bus_idle(); idle(10);
        read_chk(2'd0, 32'h5, "dis_pos_frozen");
        read_chk(2'd1, 32'h14, "dis_flags_frozen");
        wr(2'd2, 32'h100);
        step(1'b1, 10);
        read_chk(2'd0, 32'h6, "en_pos");
        read_chk(2'd1, 32'h1C, "en_stat");
        wr(2'd3, 32'h0);
        read_chk(2'd3, 32'h0, "db_zero");
        step(1'b1, 10);
        read_chk(2'd0, 32'h7, "lim0_pos");

        step(1'b1, 3);
        tick(); rst = 1'b1; bus_idle();
        step(1'b1, 3); step(1'b1, 3); step(1'b1, 3);
        tick(); rst = 1'b0; bus_idle(); idle(15);
        read_chk(2'd0, 32'h0, "rst_mid_pos");
        read_chk(2'd1, 32'h0, "rst_mid_stat");
        read_chk(2'd2, 32'h100, "rst_mid_ctrl");
        read_chk(2'd3, 32'h3, "rst_mid_db");
        step(1'b1, 10);
        read_chk(2'd0, 32'h1, "post_rst_pos");
        read_chk(2'd1, 32'h0C, "post_rst_stat");

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
